bram_rd_arbiter: RTL and testbench
==================================

// Module: bram_rd_arbiter
// PURPOSE
//  Shares the single matrix-BRAM read port among NUM_REQ requesters (operation selector,
//  operation executor, UART result dumper). Round-robin arbitration with optional burst lock;
//  tags each issued read and routes returned data, with its valid, back to the issuing requester.
//  Replaces the static state-based address mux in the compute subsystem.
// PARAMETERS
//  NUM_REQ     3    number of requesters; index 0 = selector, 1 = executor, 2 = dumper
//  ADDR_WIDTH  14   BRAM word address width
//  DATA_WIDTH  32   BRAM data width
//  RD_LATENCY  1    BRAM cycles from address to data (>=1)
//  MAX_BURST   16   max reads issued per locked grant before forced rotation
// PORTS
//  clk           in   1                    clock
//  rst_n         in   1                    asynchronous, active-low reset
//  req           in   NUM_REQ              per-requester read request (level)
//  lock          in   NUM_REQ              keep grant across consecutive reads (burst)
//  req_addr      in   NUM_REQ*ADDR_WIDTH   packed addresses; slice i belongs to requester i
//  gnt           out  NUM_REQ              one-hot grant, registered
//  rd_valid      out  NUM_REQ              one-hot: rd_data is valid for requester i
//  rd_data       out  DATA_WIDTH           returned data, broadcast to all requesters
//  bram_rd_addr  out  ADDR_WIDTH           to BRAM read port
//  bram_rd_data  in   DATA_WIDTH           from BRAM read port
//  owner_id      out  $clog2(NUM_REQ)      current/last owner, for debug LEDs
// BEHAVIOUR
//  Reset: gnt=0, rd_valid=0, rd_data=0, bram_rd_addr=0, owner_id=0, burst_cnt=0,
//   RR pointer set so requester 0 has top priority; all in-flight tags cleared.
//  States: IDLE (no owner), OWNED (gnt[owner_id]=1).
//  IDLE: any req -> winner = first set req scanning from (last_owner+1) mod NUM_REQ;
//   owner_id<=winner, gnt<=onehot(winner), ->OWNED. Grant latency: 1 cycle after req seen.
//  Read issue: a read is issued in every cycle with gnt[i]&&req[i]; bram_rd_addr =
//   req_addr slice of owner (combinational from owner_id, holds last value while IDLE).
//  Return: issued read's owner tag shifts through a RD_LATENCY-deep pipe; exactly RD_LATENCY
//   cycles after issue, rd_valid[tag]=1 for one cycle and rd_data=bram_rd_data (passed through
//   combinationally with the tag). Back-to-back reads give back-to-back rd_valid.
//  Release (evaluated each OWNED cycle):
//   - req[owner]=0 while granted: no read issued, release.
//   - lock[owner]=0: release after the single read issued this cycle.
//   - lock[owner]=1: hold; burst_cnt++ per issued read; release on the read that makes
//     burst_cnt==MAX_BURST.
//  Hand-off: on release, if any req pending (incl. the releasing one), the next winner (RR from
//   owner+1) is granted the following cycle with no idle bubble; else ->IDLE, gnt=0.
//   burst_cnt resets to 0 on every new grant. Sole requester at MAX_BURST is re-granted
//   itself (rotation is fairness, not a stall).
//  Data of a read issued in the release cycle is still returned to the old owner even if the
//   new owner's reads follow; tags keep returns ordered and unambiguous.
//  req raised by a non-owner while OWNED waits; never more than one gnt bit set.
//  Requesters must hold req_addr stable only in the cycle they are granted; addresses may
//   change every granted cycle (streaming).
//  Reset mid-operation: grant dropped immediately, pending returns discarded (no rd_valid).
// STRUCTURE
//  Shared package bram_arb_pkg: arb_state_t {ARB_IDLE, ARB_OWNED}; requester index localparams
//   REQ_SELECTOR=0, REQ_EXECUTOR=1, REQ_DUMPER=2.
//  Sub-module rr_priority_picker (combinational: req vector + start index -> one-hot winner,
//   any_valid); arbiter, burst counter and tag pipe live in this module.
// TESTING
//  1 req=001 only, lock=0, addrs 5,6,7 streamed -> gnt=001 from cycle 2, reads issued for
//    5,6,7 with same owner re-granted each time, rd_valid=001 RD_LATENCY after each issue.
//  2 req=111 constant, lock=0 -> grants rotate 001,010,100,001..., one read each, no bubble.
//  3 req=011, lock[1]=1, MAX_BURST=16 -> requester 1 issues exactly 16 reads, then gnt=001
//    next cycle; requester 1 regranted after requester 0's read.
//  4 owner 2 releases in cycle N with read at addr 100; owner 0 reads addr 7 in N+1 ->
//    rd_valid=100 with data[100] at N+RD_LATENCY, rd_valid=001 with data[7] next cycle.
//  5 rst_n pulsed low while owner 1 mid-burst with reads in flight -> gnt=0, rd_valid=0
//    immediately; no stale rd_valid after release; requester 0 wins first arbitration.
//  6 req[owner] dropped while granted -> no read issued, no rd_valid, gnt moves or clears.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and requester indices for the matrix-BRAM read arbiter
package bram_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_t;

  localparam int REQ_SELECTOR = 0;
  localparam int REQ_EXECUTOR = 1;
  localparam int REQ_DUMPER   = 2;

endpackage

// File: rtl/bram_rd_arbiter_if.sv
// rtl/bram_rd_arbiter_if.sv - requester/BRAM bus around the shared read port
interface bram_rd_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic [ADDR_WIDTH-1:0]         bram_rd_addr;
  logic [DATA_WIDTH-1:0]         bram_rd_data;
  logic [IDX_W-1:0]              owner_id;

  // Arbiter side
  modport slave (
    input  req, lock, req_addr, bram_rd_data,
    output gnt, rd_valid, rd_data, bram_rd_addr, owner_id
  );

  // Requesters plus the BRAM itself
  modport master (
    output req, lock, req_addr, bram_rd_data,
    input  gnt, rd_valid, rd_data, bram_rd_addr, owner_id
  );

endinterface

// File: rtl/bram_rd_arbiter_rr_priority_picker.sv
// rtl/bram_rd_arbiter_rr_priority_picker.sv - combinational round-robin winner select
module rr_priority_picker
  import bram_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     winner,
  output logic             any_valid
);

  logic [N-1:0] req_rot;
  logic [N-1:0] win_rot;
  logic         found;

  // Rotate so bit 0 is the start index, pick the lowest set bit, rotate back.
  always_comb begin
    req_rot = N'({req, req} >> start);
    win_rot = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        win_rot[k] = 1'b1;
        found      = 1'b1;
      end
    end
    winner    = N'(({win_rot, win_rot} << start) >> N);
    any_valid = |req;
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// rtl/bram_rd_arbiter.sv - round-robin, burst-lockable arbiter for the shared matrix-BRAM read port
module bram_rd_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_rd_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [CNT_W-1:0]      burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [IDX_W-1:0]      pipe_tag [RD_LATENCY];

  logic                  req_own;
  logic                  lock_own;
  logic                  issue;
  logic                  release_own;
  logic [ADDR_WIDTH-1:0] owner_addr;
  logic [IDX_W-1:0]      rr_start;
  logic [NUM_REQ-1:0]    win_onehot;
  logic                  any_req;
  logic [IDX_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]    rd_valid_c;

  assign req_own  = bus.req[owner_q];
  assign lock_own = bus.lock[owner_q];
  assign issue    = (state_q == ARB_OWNED) && req_own;
  assign rr_start = (rr_ptr_q == IDX_W'(NUM_REQ - 1)) ? '0 : rr_ptr_q + 1'b1;

  always_comb begin
    owner_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (bus.req),
    .start     (rr_start),
    .winner    (win_onehot),
    .any_valid (any_req)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end

  // IDLE behaves as a permanent hand-off point, so arbitration has a single path.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    burst_d     = burst_q;
    release_own = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        release_own = 1'b1;
      end
      ARB_OWNED: begin
        if (!req_own || !lock_own || (burst_q == CNT_W'(MAX_BURST - 1))) begin
          release_own = 1'b1;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    if (release_own) begin
      if (any_req) begin
        state_d  = ARB_OWNED;
        owner_d  = win_idx;
        rr_ptr_d = win_idx;
        gnt_d    = win_onehot;
        burst_d  = '0;
      end else begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        burst_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= IDX_W'(REQ_SELECTOR);
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      burst_q     <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      burst_q  <= burst_d;
      if (issue) begin
        addr_hold_q <= owner_addr;
      end
    end
  end

  // Owner tag travels alongside the BRAM latency so returns route to the issuer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_tag[s] <= '0;
      end
    end else begin
      pipe_vld[0] <= issue;
      pipe_tag[0] <= owner_q;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_tag[s] <= pipe_tag[s-1];
      end
    end
  end

  always_comb begin
    rd_valid_c = '0;
    if (pipe_vld[RD_LATENCY-1]) begin
      rd_valid_c[pipe_tag[RD_LATENCY-1]] = 1'b1;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.owner_id     = owner_q;
  assign bus.rd_valid     = rd_valid_c;
  assign bus.rd_data      = pipe_vld[RD_LATENCY-1] ? bus.bram_rd_data : '0;
  assign bus.bram_rd_addr = (state_q == ARB_OWNED) ? owner_addr : addr_hold_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_gnt_state  : assert property (@(posedge clk) disable iff (!rst_n)
                                  (state_q == ARB_OWNED) == (gnt_q != '0));
  a_gnt_owner  : assert property (@(posedge clk) disable iff (!rst_n)
                                  (state_q == ARB_OWNED) |-> gnt_q[owner_q]);

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// tb/tb_bram_rd_arbiter.sv - directed self-checking bench for bram_rd_arbiter
module tb_bram_rd_arbiter;
  import bram_arb_pkg::*;

  localparam int NUM_REQ    = 3;
  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 32;
  localparam int RD_LATENCY = 1;
  localparam int MAX_BURST  = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bram_rd_arbiter_if #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) bus ();

  bram_rd_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM content: word at address a is 0xDA7A0000 | a
  always @(posedge clk) begin
    bus.bram_rd_data <= 32'hDA7A_0000 | {18'h0, bus.bram_rd_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int idx, input int a);
    bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(a);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.lock     = '0;
    bus.req_addr = '0;

    // Reset values
    repeat (3) tick();
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_rd_data", bus.rd_data, 32'h0);
    chk("rst_bram_addr", 32'(bus.bram_rd_addr), 32'h0);
    chk("rst_owner", 32'(bus.owner_id), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: sole requester 0 streams 5,6,7
    bus.req = 3'b001;
    set_addr(REQ_SELECTOR, 5);
    #1;
    chk("t1_gnt_wait", 32'(bus.gnt), 32'h0);
    tick();
    chk("t1_gnt_c1", 32'(bus.gnt), 32'h1);
    chk("t1_addr_5", 32'(bus.bram_rd_addr), 32'd5);
    chk("t1_rv_c1", 32'(bus.rd_valid), 32'h0);
    tick();
    set_addr(REQ_SELECTOR, 6);
    #1;
    chk("t1_gnt_c2", 32'(bus.gnt), 32'h1);
    chk("t1_addr_6", 32'(bus.bram_rd_addr), 32'd6);
    chk("t1_rv_c2", 32'(bus.rd_valid), 32'h1);
    chk("t1_data_5", bus.rd_data, 32'hDA7A_0005);
    tick();
    set_addr(REQ_SELECTOR, 7);
    #1;
    chk("t1_addr_7", 32'(bus.bram_rd_addr), 32'd7);
    chk("t1_rv_c3", 32'(bus.rd_valid), 32'h1);
    chk("t1_data_6", bus.rd_data, 32'hDA7A_0006);
    tick();
    bus.req = 3'b000;
    #1;
    chk("t1_gnt_c4", 32'(bus.gnt), 32'h1);
    chk("t1_rv_c4", 32'(bus.rd_valid), 32'h1);
    chk("t1_data_7", bus.rd_data, 32'hDA7A_0007);
    tick();
    chk("t1_gnt_idle", 32'(bus.gnt), 32'h0);
    chk("t1_rv_idle", 32'(bus.rd_valid), 32'h0);
    chk("t1_addr_hold", 32'(bus.bram_rd_addr), 32'd7);

    // 2: all three requesting, lock=0 -> rotation from last owner 0
    bus.req = 3'b111;
    set_addr(REQ_SELECTOR, 10);
    set_addr(REQ_EXECUTOR, 20);
    set_addr(REQ_DUMPER, 30);
    #1;
    chk("t2_gnt_wait", 32'(bus.gnt), 32'h0);
    tick();
    chk("t2_gnt_1", 32'(bus.gnt), 32'h2);
    chk("t2_addr_20", 32'(bus.bram_rd_addr), 32'd20);
    chk("t2_rv_0", 32'(bus.rd_valid), 32'h0);
    tick();
    chk("t2_gnt_2", 32'(bus.gnt), 32'h4);
    chk("t2_addr_30", 32'(bus.bram_rd_addr), 32'd30);
    chk("t2_rv_1", 32'(bus.rd_valid), 32'h2);
    chk("t2_data_20", bus.rd_data, 32'hDA7A_0014);
    tick();
    chk("t2_gnt_0", 32'(bus.gnt), 32'h1);
    chk("t2_addr_10", 32'(bus.bram_rd_addr), 32'd10);
    chk("t2_rv_2", 32'(bus.rd_valid), 32'h4);
    chk("t2_data_30", bus.rd_data, 32'hDA7A_001E);
    tick();
    bus.req = 3'b000;
    #1;
    chk("t2_gnt_1b", 32'(bus.gnt), 32'h2);
    chk("t2_rv_0b", 32'(bus.rd_valid), 32'h1);
    chk("t2_data_10", bus.rd_data, 32'hDA7A_000A);
    tick();
    chk("t6_gnt_clear", 32'(bus.gnt), 32'h0);
    chk("t6_rv_none", 32'(bus.rd_valid), 32'h0);

    // 3: requester 1 locked burst of MAX_BURST reads, requester 0 waiting
    bus.req  = 3'b010;
    bus.lock = 3'b010;
    set_addr(REQ_SELECTOR, 50);
    #1;
    tick();
    bus.req = 3'b011;
    for (int i = 0; i < MAX_BURST; i++) begin
      set_addr(REQ_EXECUTOR, 40 + i);
      #1;
      chk("t3_burst_gnt", 32'(bus.gnt), 32'h2);
      chk("t3_burst_addr", 32'(bus.bram_rd_addr), 32'(40 + i));
      if (i > 0) begin
        chk("t3_burst_rv", 32'(bus.rd_valid), 32'h2);
        chk("t3_burst_data", bus.rd_data, 32'hDA7A_0000 + 32'(40 + i - 1));
      end
      tick();
    end
    #1;
    chk("t3_rot_gnt", 32'(bus.gnt), 32'h1);
    chk("t3_rot_addr", 32'(bus.bram_rd_addr), 32'd50);
    chk("t3_rot_rv", 32'(bus.rd_valid), 32'h2);
    chk("t3_rot_data", bus.rd_data, 32'hDA7A_0037);
    tick();
    set_addr(REQ_EXECUTOR, 60);
    #1;
    chk("t3_regnt_gnt", 32'(bus.gnt), 32'h2);
    chk("t3_regnt_addr", 32'(bus.bram_rd_addr), 32'd60);
    chk("t3_regnt_rv", 32'(bus.rd_valid), 32'h1);
    chk("t3_regnt_data", bus.rd_data, 32'hDA7A_0032);
    tick();
    chk("t5_pre_gnt", 32'(bus.gnt), 32'h2);
    chk("t5_pre_rv", 32'(bus.rd_valid), 32'h2);
    chk("t5_pre_data", bus.rd_data, 32'hDA7A_003C);

    // 5: asynchronous reset while requester 1 is mid-burst with a read in flight
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("t5_rst_rv", 32'(bus.rd_valid), 32'h0);
    chk("t5_rst_data", bus.rd_data, 32'h0);
    chk("t5_rst_owner", 32'(bus.owner_id), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_rel_gnt", 32'(bus.gnt), 32'h0);
    chk("t5_rel_rv", 32'(bus.rd_valid), 32'h0);
    tick();
    chk("t5_first_gnt", 32'(bus.gnt), 32'h1);
    chk("t5_first_owner", 32'(bus.owner_id), 32'(REQ_SELECTOR));
    chk("t5_first_rv", 32'(bus.rd_valid), 32'h0);
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    #1;
    tick();
    chk("t6_drop_gnt", 32'(bus.gnt), 32'h0);
    chk("t6_drop_rv", 32'(bus.rd_valid), 32'h0);

    // 4: owner 2 releases reading 100, owner 0 reads 7 the next cycle
    bus.req = 3'b100;
    set_addr(REQ_DUMPER, 100);
    set_addr(REQ_SELECTOR, 7);
    #1;
    tick();
    bus.req = 3'b101;
    #1;
    chk("t4_gnt_n", 32'(bus.gnt), 32'h4);
    chk("t4_addr_100", 32'(bus.bram_rd_addr), 32'd100);
    tick();
    bus.req = 3'b001;
    #1;
    chk("t4_gnt_n1", 32'(bus.gnt), 32'h1);
    chk("t4_addr_7", 32'(bus.bram_rd_addr), 32'd7);
    chk("t4_rv_n1", 32'(bus.rd_valid), 32'h4);
    chk("t4_data_100", bus.rd_data, 32'hDA7A_0064);
    tick();
    bus.req = 3'b000;
    #1;
    chk("t4_rv_n2", 32'(bus.rd_valid), 32'h1);
    chk("t4_data_7", bus.rd_data, 32'hDA7A_0007);
    tick();
    chk("t4_gnt_end", 32'(bus.gnt), 32'h0);
    chk("t4_rv_end", 32'(bus.rd_valid), 32'h0);

    // 6: owner drops req while another is pending -> grant moves, nothing issued
    bus.req = 3'b001;
    #1;
    tick();
    bus.req = 3'b010;
    #1;
    chk("t6_mv_gnt0", 32'(bus.gnt), 32'h1);
    tick();
    chk("t6_mv_gnt1", 32'(bus.gnt), 32'h2);
    chk("t6_mv_rv", 32'(bus.rd_valid), 32'h0);
    bus.req = 3'b000;
    #1;
    tick();
    chk("t6_mv_clear", 32'(bus.gnt), 32'h0);
    chk("t6_mv_rv2", 32'(bus.rd_valid), 32'h0);
    chk("t6_mv_owner", 32'(bus.owner_id), 32'(REQ_EXECUTOR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
